// File: rtl/i2s_defs.sv
// Shared I2S definitions: receiver FSM encoding, word-select polarity and default width.
// audio_out uses LR_LEFT and DATA_W_DEF from here as well.
package i2s_defs;

   localparam int   DATA_W_DEF = 16;
   localparam logic LR_LEFT    = 1'b0;

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } i2s_state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge detector; rise_o is a one-clk pulse per input rise.
module i2s_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic rise_o
);

   logic s1_q, s2_q, s3_q, rise_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         s3_q   <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         s1_q   <= async_i;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         rise_q <= s2_q & ~s3_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples BCLK/LRCK/DATA with clk and delivers one
// left/right pair per frame with a single-cycle valid strobe.
module i2s_rx
   import i2s_defs::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i2s_bclk,
   input  logic              i2s_lrclk,
   input  logic              i2s_data,
   output logic [DATA_W-1:0] sample_l,
   output logic [DATA_W-1:0] sample_r,
   output logic              sample_valid,
   output logic              locked,
   output logic              frame_err
);

   localparam int              IDX_W    = $clog2(DATA_W + 2);
   localparam int              CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(DATA_W);
   localparam logic [IDX_W-1:0] IDX_SAT  = IDX_W'(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_TMO  = CNT_W'(TIMEOUT);

   logic       bclk_rise;
   logic [1:0] lr_sync_q, dat_sync_q;
   logic       lr_q, dat_q;

   i2s_sync_edge u_bclk_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (i2s_bclk),
      .rise_o  (bclk_rise)
   );

   // LRCK/DATA get one extra stage so they line up with the registered rise pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         lr_sync_q  <= '0;
         dat_sync_q <= '0;
         lr_q       <= 1'b0;
         dat_q      <= 1'b0;
      end else begin
         lr_sync_q  <= {lr_sync_q[0], i2s_lrclk};
         dat_sync_q <= {dat_sync_q[0], i2s_data};
         lr_q       <= lr_sync_q[1];
         dat_q      <= dat_sync_q[1];
      end
   end

   i2s_state_e        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [DATA_W-1:0] hold_l_q, hold_l_d;
   logic [DATA_W-1:0] hold_r_q, hold_r_d;
   logic              lr_prev_q, lr_prev_d;
   logic              left_ok_q, left_ok_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              tmo_hit;
   logic              pair_q, pair_d;
   logic              err_q, err_d;
   logic              tmo_q, tmo_d;

   assign tmo_hit = !bclk_rise && (cnt_q == CNT_TMO - 1'b1);

   always_comb begin
      cnt_d = cnt_q;
      if (bclk_rise)
         cnt_d = '0;
      else if (cnt_q != CNT_TMO)
         cnt_d = cnt_q + 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      hold_l_d  = hold_l_q;
      hold_r_d  = hold_r_q;
      lr_prev_d = lr_prev_q;
      left_ok_d = left_ok_q;
      pair_d    = 1'b0;
      err_d     = 1'b0;
      tmo_d     = 1'b0;

      if (bclk_rise) begin
         lr_prev_d = lr_q;
         if (lr_q != lr_prev_q) begin
            // Delay-slot rise: close the slot that just ended
            idx_d = '0;
            unique case (state_q)
               ST_SYNC: begin
                  if (lr_q == LR_LEFT) begin
                     state_d   = ST_LEFT;
                     left_ok_d = 1'b0;
                  end
               end
               ST_LEFT: begin
                  state_d = ST_RIGHT;
                  if (idx_q < IDX_FULL) begin
                     err_d     = 1'b1;
                     left_ok_d = 1'b0;
                  end else begin
                     left_ok_d = 1'b1;
                  end
               end
               ST_RIGHT: begin
                  state_d = ST_LEFT;
                  if (idx_q < IDX_FULL)
                     err_d = 1'b1;
                  else if (left_ok_q)
                     pair_d = 1'b1;
               end
               default: state_d = ST_SYNC;
            endcase
         end else if (idx_q != IDX_SAT) begin
            idx_d = idx_q + 1'b1;
            if (idx_d <= IDX_FULL) begin
               shreg_d = {shreg_q[DATA_W-2:0], dat_q};
               if (idx_d == IDX_FULL) begin
                  if (lr_q == LR_LEFT)
                     hold_l_d = shreg_d;
                  else
                     hold_r_d = shreg_d;
               end
            end
         end
      end

      if (tmo_hit) begin
         state_d   = ST_SYNC;
         left_ok_d = 1'b0;
         tmo_d     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_SYNC;
         idx_q     <= '0;
         shreg_q   <= '0;
         hold_l_q  <= '0;
         hold_r_q  <= '0;
         lr_prev_q <= 1'b0;
         left_ok_q <= 1'b0;
         cnt_q     <= '0;
         pair_q    <= 1'b0;
         err_q     <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         hold_l_q  <= hold_l_d;
         hold_r_q  <= hold_r_d;
         lr_prev_q <= lr_prev_d;
         left_ok_q <= left_ok_d;
         cnt_q     <= cnt_d;
         pair_q    <= pair_d;
         err_q     <= err_d;
         tmo_q     <= tmo_d;
      end
   end

   logic [DATA_W-1:0] sample_l_q, sample_r_q;
   logic              valid_q, locked_q, ferr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sample_l_q <= '0;
         sample_r_q <= '0;
         valid_q    <= 1'b0;
         locked_q   <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         valid_q <= pair_q;
         ferr_q  <= err_q;
         if (pair_q) begin
            sample_l_q <= hold_l_q;
            sample_r_q <= hold_r_q;
         end
         if (tmo_q)
            locked_q <= 1'b0;
         else if (pair_q)
            locked_q <= 1'b1;
      end
   end

   assign sample_l     = sample_l_q;
   assign sample_r     = sample_r_q;
   assign sample_valid = valid_q;
   assign locked       = locked_q;
   assign frame_err    = ferr_q;

endmodule
